kuuga_dm_cache_ctrl: RTL and testbench
======================================

KUUGA_DM_CACHE_CTRL -- requirements
Module: kuuga_dm_cache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, byte-address width of core and BRAM ports.
REQ-002 SHALL have parameter LINES, default 16, number of one-word direct-mapped lines (power of two).
REQ-003 SHALL have one clock, port clk, input, 1, rising-edge clock for all state.
REQ-004 SHALL have reset port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port flush, input, 1, pulse invalidating all lines.
REQ-006 SHALL have port data_req, input, 1, core request valid.
REQ-007 SHALL have port data_gnt, output, 1, request accepted this cycle.
REQ-008 SHALL have ports data_addr (input, ADDR_W, byte address), data_we (input, 1, write), data_be (input, 4, byte enables), data_wdata (input, 32, write data).
REQ-009 SHALL have ports data_rvalid (output, 1, response valid) and data_rdata (output, 32, read data).
REQ-010 SHALL have ports data_bram_clk_a (output, 1), data_bram_rst_a (output, 1), data_bram_en_a (output, 1), data_bram_we_a (output, 4), data_bram_addr_a (output, ADDR_W, byte address), data_bram_wrdata_a (output, 32), data_bram_rddata_a (input, 32): BRAM port A with 1-cycle read latency.
REQ-011 SHALL have ports hit_count and miss_count, output, 32 each, statistics.

Function
REQ-012 SHALL split data_addr: offset [1:0] ignored, index [log2(LINES)+1:2], tag = remaining upper bits.
REQ-013 SHALL drive data_bram_clk_a = clk and data_bram_rst_a = 0; all other BRAM outputs registered, address bits [1:0] always 0.
REQ-014 SHALL implement states IDLE, HIT_RESP, MISS_REQ, MISS_WAIT, WRITE; data_gnt = data_req only in IDLE with flush low, else 0.
REQ-015 Read hit (valid and tag match) accepted cycle N: HIT_RESP in N+1 with data_rvalid=1, data_rdata=line data; IDLE in N+2; hit_count+1.
REQ-016 Read miss accepted cycle N: MISS_REQ in N+1 with en=1, we=0, addr=line address; MISS_WAIT in N+2 with data_rvalid=1, data_rdata=data_bram_rddata_a, line filled (valid=1, new tag); IDLE in N+3; miss_count+1.
REQ-017 Write accepted cycle N (write-through, no-write-allocate): WRITE in N+1 with en=1, we=data_be, wrdata=data_wdata, data_rvalid=1; on hit only enabled bytes of the line updated; miss leaves cache unchanged; IDLE in N+2; counters unchanged.
REQ-018 data_be=0 write SHALL still complete handshake with BRAM we=0 and no line change.
REQ-019 flush high in IDLE SHALL clear every valid bit that cycle and suppress data_gnt; flush outside IDLE SHALL be ignored.
REQ-020 hit_count and miss_count SHALL saturate at 0xFFFFFFFF.
REQ-021 data_en/we/rvalid SHALL be 0 in every cycle not listed above; data_rdata holds last value.

Reset
REQ-022 reset SHALL asynchronously force IDLE, all valid bits 0, counters 0, data_rvalid 0, data_rdata 0, BRAM en/we/addr/wrdata 0, including mid-miss or mid-write (in-flight response dropped).
REQ-023 tag/data arrays SHALL need no reset.

Structure
REQ-024 Package kuuga_dm_cache_pkg SHALL hold the state enum, default ADDR_W/LINES, and derived INDEX_W/TAG_W functions.
REQ-025 Storage SHALL live in one sub-module kuuga_dm_cache_array (valid/tag/data, byte-enable write, flash invalidate, combinational read).

Verification
REQ-026 Cold read addr 0x0040 (BRAM word 0x11223344) -> miss: en=1 addr 0x0040 cycle N+1, rvalid rdata 0x11223344 N+2, miss_count=1.
REQ-027 Repeat read 0x0040 -> rvalid N+1 rdata 0x11223344, no BRAM en, hit_count=1.
REQ-028 Write 0x0040 be=4'b0011 wdata 0xAAAABBBB -> BRAM we=0011 N+1; next read 0x0040 hits, rdata 0x1122BBBB.
REQ-029 Read 0x0080 (same index 0, different tag) after 0x0040 -> miss, refill; then read 0x0040 -> miss again.
REQ-030 flush with data_req high -> data_gnt=0 that cycle; following read 0x0080 -> miss.
REQ-031 reset asserted in MISS_WAIT cycle -> no rvalid, en=0 immediately, counters 0, next read 0x0040 misses.

Source files
------------

// File: rtl/kuuga_dm_cache_pkg.sv
// Shared types and sizing helpers for the direct-mapped data cache controller.
//   state_e      : controller FSM states
//   DEF_ADDR_W   : default byte-address width
//   DEF_LINES    : default number of one-word lines
//   index_w/tag_w: address field widths derived from ADDR_W and LINES
//   sat_inc      : saturating 32-bit increment for the statistics counters
package kuuga_dm_cache_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_LINES  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HIT_RESP,
    ST_MISS_REQ,
    ST_MISS_WAIT,
    ST_WRITE
  } state_e;

  function automatic int unsigned index_w(int unsigned lines);
    return 32'($clog2(lines));
  endfunction

  // Two low bits are the byte offset inside the 32-bit line.
  function automatic int unsigned tag_w(int unsigned addr_w, int unsigned lines);
    return addr_w - 32'd2 - index_w(lines);
  endfunction

  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/kuuga_dm_cache_array.sv
// Valid/tag/data storage for the direct-mapped cache.
//   clk, rst   : clock, asynchronous active-high reset (valid bits only)
//   inval_i    : flash-clear every valid bit
//   we_i       : write line wr_idx_i: set valid, store tag, update enabled bytes
//   rd_idx_i   : combinational read index -> rd_valid_o/rd_tag_o/rd_data_o
module kuuga_dm_cache_array
  import kuuga_dm_cache_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned LINES  = DEF_LINES
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                inval_i,
  input  logic                                we_i,
  input  logic [index_w(LINES)-1:0]           wr_idx_i,
  input  logic [tag_w(ADDR_W, LINES)-1:0]     wr_tag_i,
  input  logic [3:0]                          be_i,
  input  logic [31:0]                         wr_data_i,
  input  logic [index_w(LINES)-1:0]           rd_idx_i,
  output logic                                rd_valid_o,
  output logic [tag_w(ADDR_W, LINES)-1:0]     rd_tag_o,
  output logic [31:0]                         rd_data_o
);

  localparam int unsigned TAG_W = tag_w(ADDR_W, LINES);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  // Valid bits: flash invalidate has priority over a line write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (inval_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data need no reset; they are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          data_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/kuuga_dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache in front of a
// single-port BRAM with 1-cycle read latency.
//   clk, reset          : clock, asynchronous active-high reset
//   flush               : invalidate all lines (honoured only while idle)
//   data_*              : core request/grant and response interface
//   data_bram_*_a       : BRAM port A (byte address, word aligned)
//   hit_count/miss_count: saturating read statistics
module kuuga_dm_cache_ctrl
  import kuuga_dm_cache_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned LINES  = DEF_LINES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              data_req,
  output logic              data_gnt,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic              data_we,
  input  logic [3:0]        data_be,
  input  logic [31:0]       data_wdata,
  output logic              data_rvalid,
  output logic [31:0]       data_rdata,
  output logic              data_bram_clk_a,
  output logic              data_bram_rst_a,
  output logic              data_bram_en_a,
  output logic [3:0]        data_bram_we_a,
  output logic [ADDR_W-1:0] data_bram_addr_a,
  output logic [31:0]       data_bram_wrdata_a,
  input  logic [31:0]       data_bram_rddata_a,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int unsigned INDEX_W = index_w(LINES);
  localparam int unsigned TAG_W   = tag_w(ADDR_W, LINES);

  state_e              state_q, state_d;
  logic [INDEX_W-1:0]  fill_idx_q, fill_idx_d;
  logic [TAG_W-1:0]    fill_tag_q, fill_tag_d;
  logic                rvalid_q, rvalid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                en_q, en_d;
  logic [3:0]          we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wrdata_q, wrdata_d;
  logic [31:0]         hit_q, hit_d;
  logic [31:0]         miss_q, miss_d;

  logic [INDEX_W-1:0]  req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [ADDR_W-1:0]   req_line_addr;
  logic                arr_inval, arr_we;
  logic [INDEX_W-1:0]  arr_idx;
  logic [TAG_W-1:0]    arr_tag;
  logic [3:0]          arr_be;
  logic [31:0]         arr_wdata;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [31:0]         rd_data;
  logic                lookup_hit;
  logic                unused_offset;

  assign req_idx       = data_addr[INDEX_W+1:2];
  assign req_tag       = data_addr[ADDR_W-1:INDEX_W+2];
  assign req_line_addr = {data_addr[ADDR_W-1:2], 2'b00};
  assign lookup_hit    = rd_valid && (rd_tag == req_tag);
  assign unused_offset = ^data_addr[1:0];

  kuuga_dm_cache_array #(
    .ADDR_W (ADDR_W),
    .LINES  (LINES)
  ) u_array (
    .clk        (clk),
    .rst        (reset),
    .inval_i    (arr_inval),
    .we_i       (arr_we),
    .wr_idx_i   (arr_idx),
    .wr_tag_i   (arr_tag),
    .be_i       (arr_be),
    .wr_data_i  (arr_wdata),
    .rd_idx_i   (req_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data)
  );

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fill_idx_q <= '0;
      fill_tag_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      en_q       <= 1'b0;
      we_q       <= '0;
      addr_q     <= '0;
      wrdata_q   <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      fill_idx_q <= fill_idx_d;
      fill_tag_q <= fill_tag_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      en_q       <= en_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wrdata_q   <= wrdata_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
    end
  end

  // Next state, next registered outputs, array controls.
  always_comb begin
    state_d    = state_q;
    fill_idx_d = fill_idx_q;
    fill_tag_d = fill_tag_q;
    rvalid_d   = 1'b0;
    rdata_d    = rdata_q;
    en_d       = 1'b0;
    we_d       = 4'b0000;
    addr_d     = addr_q;
    wrdata_d   = wrdata_q;
    hit_d      = hit_q;
    miss_d     = miss_q;
    data_gnt   = 1'b0;
    arr_inval  = 1'b0;
    arr_we     = 1'b0;
    arr_idx    = req_idx;
    arr_tag    = req_tag;
    arr_be     = 4'b0000;
    arr_wdata  = data_wdata;

    unique case (state_q)
      ST_IDLE: begin
        if (flush) begin
          arr_inval = 1'b1;
        end else if (data_req) begin
          data_gnt   = 1'b1;
          fill_idx_d = req_idx;
          fill_tag_d = req_tag;
          if (data_we) begin
            // Write-through; the line is only touched when already present.
            state_d  = ST_WRITE;
            en_d     = 1'b1;
            we_d     = data_be;
            addr_d   = req_line_addr;
            wrdata_d = data_wdata;
            rvalid_d = 1'b1;
            arr_we   = lookup_hit;
            arr_be   = data_be;
          end else if (lookup_hit) begin
            state_d  = ST_HIT_RESP;
            rvalid_d = 1'b1;
            rdata_d  = rd_data;
            hit_d    = sat_inc(hit_q);
          end else begin
            state_d  = ST_MISS_REQ;
            en_d     = 1'b1;
            addr_d   = req_line_addr;
            miss_d   = sat_inc(miss_q);
          end
        end
      end
      ST_HIT_RESP: state_d = ST_IDLE;
      ST_MISS_REQ: begin
        state_d  = ST_MISS_WAIT;
        rvalid_d = 1'b1;
      end
      ST_MISS_WAIT: begin
        // BRAM data is valid this cycle: refill the line and keep a copy.
        state_d   = ST_IDLE;
        rdata_d   = data_bram_rddata_a;
        arr_we    = 1'b1;
        arr_idx   = fill_idx_q;
        arr_tag   = fill_tag_q;
        arr_be    = 4'b1111;
        arr_wdata = data_bram_rddata_a;
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Miss data is forwarded from the BRAM in the cycle it arrives.
  assign data_rdata         = (state_q == ST_MISS_WAIT) ? data_bram_rddata_a : rdata_q;
  assign data_rvalid        = rvalid_q;
  assign data_bram_clk_a    = clk;
  assign data_bram_rst_a    = 1'b0;
  assign data_bram_en_a     = en_q;
  assign data_bram_we_a     = we_q;
  assign data_bram_addr_a   = addr_q;
  assign data_bram_wrdata_a = wrdata_q;
  assign hit_count          = hit_q;
  assign miss_count         = miss_q;

endmodule

// File: tb/tb_kuuga_dm_cache_ctrl.sv
// Self-checking bench for kuuga_dm_cache_ctrl: directed table, flush and
// reset corner sequences, then random traffic against a line-level model.
module tb_kuuga_dm_cache_ctrl;

  localparam int K_HIT  = 0;
  localparam int K_MISS = 1;
  localparam int K_WR   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        data_req;
  logic        data_gnt;
  logic [15:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        bram_clk, bram_rst, bram_en;
  logic [3:0]  bram_we;
  logic [15:0] bram_addr;
  logic [31:0] bram_wrdata;
  logic [31:0] bram_rddata;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  kuuga_dm_cache_ctrl #(.ADDR_W(16), .LINES(16)) dut (
    .clk                (clk),
    .reset              (reset),
    .flush              (flush),
    .data_req           (data_req),
    .data_gnt           (data_gnt),
    .data_addr          (data_addr),
    .data_we            (data_we),
    .data_be            (data_be),
    .data_wdata         (data_wdata),
    .data_rvalid        (data_rvalid),
    .data_rdata         (data_rdata),
    .data_bram_clk_a    (bram_clk),
    .data_bram_rst_a    (bram_rst),
    .data_bram_en_a     (bram_en),
    .data_bram_we_a     (bram_we),
    .data_bram_addr_a   (bram_addr),
    .data_bram_wrdata_a (bram_wrdata),
    .data_bram_rddata_a (bram_rddata),
    .hit_count          (hit_count),
    .miss_count         (miss_count)
  );

  // BRAM: 1-cycle read latency, byte-enable writes, driven only by the DUT.
  logic [31:0] mem [16384];
  always @(posedge clk) begin
    if (bram_en) begin
      bram_rddata <= mem[bram_addr[15:2]];
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_addr[15:2]][8*b +: 8] <= bram_wrdata[8*b +: 8];
    end
  end

  // Reference model: what memory and each cache line should contain.
  logic [31:0] exp_mem [16384];
  bit          m_valid [16];
  logic [9:0]  m_tag   [16];
  logic [31:0] m_data  [16];
  logic [31:0] m_hits, m_misses;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          kind;
    logic [31:0] rd;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                        input logic [31:0] wd);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic bit m_is_hit(input logic [15:0] a);
    return m_valid[a[5:2]] && (m_tag[a[5:2]] == a[15:6]);
  endfunction

  task automatic predict(input logic we, input logic [15:0] a, output int kind,
                         output logic [31:0] rd);
    rd = 32'h0;
    if (we) kind = K_WR;
    else if (m_is_hit(a)) begin kind = K_HIT; rd = m_data[a[5:2]]; end
    else begin kind = K_MISS; rd = exp_mem[a[15:2]]; end
  endtask

  task automatic commit(input logic we, input logic [15:0] a, input logic [3:0] be,
                        input logic [31:0] wd);
    if (we) begin
      exp_mem[a[15:2]] = merge(exp_mem[a[15:2]], be, wd);
      if (m_is_hit(a)) m_data[a[5:2]] = merge(m_data[a[5:2]], be, wd);
    end else if (m_is_hit(a)) begin
      if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 1;
    end else begin
      m_valid[a[5:2]] = 1'b1;
      m_tag[a[5:2]]   = a[15:6];
      m_data[a[5:2]]  = exp_mem[a[15:2]];
      if (m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 1;
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_misses = 0;
  endfunction

  // One transaction with cycle-exact response checks; starts at the next negedge.
  task automatic run_txn(input logic we, input logic [15:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input bit flush_mid, input int kind,
                         input logic [31:0] rd);
    @(negedge clk);
    data_req = 1'b1; data_we = we; data_addr = a; data_be = be; data_wdata = wd;
    #1 chk("gnt_idle", 32'(data_gnt), 32'd1);
    @(negedge clk);
    chk("gnt_busy", 32'(data_gnt), 32'd0);
    data_req = 1'b0;
    flush = flush_mid;
    if (kind == K_HIT) begin
      chk("hit_rvalid", 32'(data_rvalid), 32'd1);
      chk("hit_rdata", data_rdata, rd);
      chk("hit_en", 32'(bram_en), 32'd0);
    end else if (kind == K_MISS) begin
      chk("miss_rvalid_early", 32'(data_rvalid), 32'd0);
      chk("miss_en", 32'(bram_en), 32'd1);
      chk("miss_we", 32'(bram_we), 32'd0);
      chk("miss_addr", 32'(bram_addr), 32'({a[15:2], 2'b00}));
    end else begin
      chk("wr_rvalid", 32'(data_rvalid), 32'd1);
      chk("wr_en", 32'(bram_en), 32'd1);
      chk("wr_we", 32'(bram_we), 32'(be));
      chk("wr_addr", 32'(bram_addr), 32'({a[15:2], 2'b00}));
      chk("wr_wrdata", bram_wrdata, wd);
    end
    @(posedge clk);
    #1 flush = 1'b0;
    if (kind == K_MISS) begin
      @(negedge clk);
      chk("miss_rvalid", 32'(data_rvalid), 32'd1);
      chk("miss_rdata", data_rdata, rd);
      chk("miss_en_off", 32'(bram_en), 32'd0);
    end
    commit(we, a, be, wd);
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_misses);
  endtask

  // Flush in IDLE, optionally racing a request that must not be granted.
  task automatic idle_flush(input logic req);
    @(negedge clk);
    flush = 1'b1; data_req = req; data_we = 1'b0; data_addr = 16'h0080;
    #1 chk("flush_gnt", 32'(data_gnt), 32'd0);
    @(negedge clk);
    flush = 1'b0; data_req = 1'b0;
    chk("flush_rvalid", 32'(data_rvalid), 32'd0);
    chk("flush_en", 32'(bram_en), 32'd0);
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          kind;
    logic [31:0] rd, v;
    logic [15:0] a;
    logic        we;

    reset = 1'b1; flush = 1'b0; data_req = 1'b0; data_we = 1'b0;
    data_addr = '0; data_be = '0; data_wdata = '0;
    for (int i = 0; i < 16384; i++) begin
      v = $urandom;
      mem[i] <= v;
      exp_mem[i] = v;
    end
    mem[16'h0040 >> 2] <= 32'h1122_3344; exp_mem[16'h0040 >> 2] = 32'h1122_3344;
    mem[16'h0080 >> 2] <= 32'h5566_7788; exp_mem[16'h0080 >> 2] = 32'h5566_7788;
    m_reset();

    vecs[0] = '{1'b0, 16'h0040, 4'h0, 32'h0,         K_MISS, 32'h1122_3344};
    vecs[1] = '{1'b0, 16'h0040, 4'h0, 32'h0,         K_HIT,  32'h1122_3344};
    vecs[2] = '{1'b1, 16'h0040, 4'h3, 32'hAAAA_BBBB, K_WR,   32'h0};
    vecs[3] = '{1'b0, 16'h0042, 4'h0, 32'h0,         K_HIT,  32'h1122_BBBB};
    vecs[4] = '{1'b0, 16'h0080, 4'h0, 32'h0,         K_MISS, 32'h5566_7788};
    vecs[5] = '{1'b0, 16'h0040, 4'h0, 32'h0,         K_MISS, 32'h1122_BBBB};
    vecs[6] = '{1'b1, 16'h0040, 4'h0, 32'hFFFF_FFFF, K_WR,   32'h0};
    vecs[7] = '{1'b0, 16'h0040, 4'h0, 32'h0,         K_HIT,  32'h1122_BBBB};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_rvalid", 32'(data_rvalid), 32'd0);
    chk("rst_rdata", data_rdata, 32'd0);
    chk("rst_en", 32'(bram_en), 32'd0);
    chk("rst_we", 32'(bram_we), 32'd0);
    chk("rst_addr", 32'(bram_addr), 32'd0);
    chk("rst_wrdata", bram_wrdata, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
    chk("bram_rst", 32'(bram_rst), 32'd0);

    // Directed table: cold miss, hit, partial write, conflict refill.
    for (int i = 0; i < 8; i++)
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wd, 1'b0,
              vecs[i].kind, vecs[i].rd);
    chk("tbl_hits", hit_count, 32'd3);
    chk("tbl_misses", miss_count, 32'd3);

    // Flush racing a request, then the flushed line must miss.
    idle_flush(1'b1);
    run_txn(1'b0, 16'h0080, 4'h0, 32'h0, 1'b0, K_MISS, 32'h5566_7788);

    // Flush raised outside IDLE is ignored: the refilled line still hits.
    run_txn(1'b0, 16'h00C4, 4'h0, 32'h0, 1'b1, K_MISS, exp_mem[16'h00C4 >> 2]);
    run_txn(1'b0, 16'h00C4, 4'h0, 32'h0, 1'b0, K_HIT,  exp_mem[16'h00C4 >> 2]);

    // Reset during MISS_WAIT drops the response and clears everything.
    @(negedge clk);
    data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0040;
    @(negedge clk);
    data_req = 1'b0;
    chk("mw_en", 32'(bram_en), 32'd1);
    @(posedge clk);
    #1;
    chk("mw_rvalid_pre", 32'(data_rvalid), 32'd1);
    reset = 1'b1;
    #1;
    chk("mw_rst_rvalid", 32'(data_rvalid), 32'd0);
    chk("mw_rst_en", 32'(bram_en), 32'd0);
    chk("mw_rst_hits", hit_count, 32'd0);
    chk("mw_rst_misses", miss_count, 32'd0);
    chk("mw_rst_rdata", data_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    run_txn(1'b0, 16'h0040, 4'h0, 32'h0, 1'b0, K_MISS, exp_mem[16'h0040 >> 2]);

    // Random traffic over 4 tags x 16 indices so hits and conflicts both occur.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        idle_flush(1'($urandom_range(0, 1)));
      end else begin
        a  = 16'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) |
                 $urandom_range(0, 3));
        we = ($urandom_range(0, 2) == 0);
        predict(we, a, kind, rd);
        run_txn(we, a, 4'($urandom_range(0, 15)), $urandom,
                ($urandom_range(0, 3) == 0), kind, rd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
